// File: rtl/jzjpcc_mmio_responder.sv
// MMIO window responder: registered output words, synchronised input words with sticky
// change flags, and a fixed ID word, served over a single-cycle-latency load/store port.
module jzjpcc_mmio_responder #(
  parameter int unsigned NUM_PORTS          = 8,
  parameter logic [31:0] OUTPUT_RESET_VALUE = 32'h0000_0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        select,
  input  logic [4:0]                  wordAddr,
  input  logic                        writeEnable,
  input  logic [3:0]                  byteWriteMask,
  input  logic [31:0]                 writeData,
  output logic [31:0]                 readData,
  output logic                        readValid,
  input  logic [NUM_PORTS-1:0][31:0]  mmioInputs,
  output logic [NUM_PORTS-1:0][31:0]  mmioOutputs
);

  localparam logic [31:0] IdValue  = 32'h4D4D_494F;
  localparam logic [4:0]  ChgAddr  = 5'd16;
  localparam logic [4:0]  IdAddr   = 5'd17;
  localparam logic [4:0]  InBase   = 5'd8;

  logic [NUM_PORTS-1:0][31:0] out_q, out_d;
  logic [NUM_PORTS-1:0][31:0] sync1_q, in_q;
  logic [NUM_PORTS-1:0]       chg_q, chg_d;
  logic [31:0]                read_data_q, read_data_d;
  logic                       read_valid_q, read_valid_d;

  logic store_req, load_req;

  assign store_req = select & writeEnable;
  assign load_req  = select & ~writeEnable;

  always_comb begin
    out_d = out_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (store_req && wordAddr == 5'(p)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (byteWriteMask[b]) out_d[p][8*b +: 8] = writeData[8*b +: 8];
        end
      end
    end
  end

  // Clear first, then apply set events so a same-edge set wins over the clear.
  always_comb begin
    chg_d = chg_q;
    if (store_req && wordAddr == ChgAddr && byteWriteMask[0]) begin
      chg_d = chg_q & ~writeData[NUM_PORTS-1:0];
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (sync1_q[p] != in_q[p]) chg_d[p] = 1'b1;
    end
  end

  always_comb begin
    read_valid_d = load_req;
    read_data_d  = read_data_q;
    if (load_req) begin
      read_data_d = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (wordAddr == 5'(p))          read_data_d = out_q[p];
        if (wordAddr == InBase + 5'(p)) read_data_d = in_q[p];
      end
      if (wordAddr == ChgAddr) read_data_d = 32'(chg_q);
      if (wordAddr == IdAddr)  read_data_d = IdValue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q        <= {NUM_PORTS{OUTPUT_RESET_VALUE}};
      sync1_q      <= '0;
      in_q         <= '0;
      chg_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      sync1_q      <= mmioInputs;
      in_q         <= sync1_q;
      chg_q        <= chg_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign mmioOutputs = out_q;
  assign readData    = read_data_q;
  assign readValid   = read_valid_q;

endmodule

// File: tb/tb_jzjpcc_mmio_responder.sv
// Self-checking bench for jzjpcc_mmio_responder: table of bus requests plus hand-written
// sequences for synchroniser latency, change flags and reset while a load is in flight.
module tb_jzjpcc_mmio_responder;

  localparam logic [31:0] Id = 32'h4D4D_494F;

  logic             clock = 1'b0;
  logic             reset;
  logic             select;
  logic [4:0]       wordAddr;
  logic             writeEnable;
  logic [3:0]       byteWriteMask;
  logic [31:0]      writeData;
  logic [31:0]      readData;
  logic             readValid;
  logic [7:0][31:0] mmio_in;
  logic [7:0][31:0] mmio_out;

  jzjpcc_mmio_responder #(
    .NUM_PORTS         (8),
    .OUTPUT_RESET_VALUE(32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .select       (select),
    .wordAddr     (wordAddr),
    .writeEnable  (writeEnable),
    .byteWriteMask(byteWriteMask),
    .writeData    (writeData),
    .readData     (readData),
    .readValid    (readValid),
    .mmioInputs   (mmio_in),
    .mmioOutputs  (mmio_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    bit          sel;
    bit          we;
    logic [4:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] last_rd;
  bit          load_issued;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge, then compare the load result (if any) against the scoreboard.
  task automatic step();
    exp_t e;
    bit   rst;
    bit   li;
    rst = reset;
    li  = load_issued;
    @(posedge clock);
    #1;
    if (rst) begin
      sb.delete();
      last_rd = '0;
    end
    check("readValid", {31'b0, readValid}, {31'b0, li});
    if (li) begin
      if (sb.size() == 0) begin
        check("scoreboard empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check(e.name, readData, e.data);
        last_rd = e.data;
      end
    end else begin
      check("readData hold", readData, last_rd);
    end
  endtask

  task automatic drive(input bit sel, input bit we, input logic [4:0] a, input logic [3:0] m,
                       input logic [31:0] wd, input logic [31:0] exp, input string name);
    exp_t e;
    select        = sel;
    writeEnable   = we;
    wordAddr      = a;
    byteWriteMask = m;
    writeData     = wd;
    load_issued   = sel && !we && !reset;
    if (load_issued) begin
      e.name = name;
      e.data = exp;
      sb.push_back(e);
    end
  endtask

  task automatic req(input bit sel, input bit we, input logic [4:0] a, input logic [3:0] m,
                     input logic [31:0] wd, input logic [31:0] exp, input string name);
    drive(sel, we, a, m, wd, exp, name);
    step();
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, "idle");
    step();
  endtask

  function automatic vec_t mk(input string name, input bit sel, input bit we,
                              input logic [4:0] a, input logic [3:0] m,
                              input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.name  = name;
    v.sel   = sel;
    v.we    = we;
    v.addr  = a;
    v.mask  = m;
    v.wdata = wd;
    v.exp   = exp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk("st3 full",      1, 1, 5'd3,  4'b1111, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st3 low half",  1, 1, 5'd3,  4'b0011, 32'h00001234, 32'h0));
    vecs.push_back(mk("ld3",           1, 0, 5'd3,  4'b0000, 32'h0,        32'hDEAD1234));
    vecs.push_back(mk("st0 bytes 1,3", 1, 1, 5'd0,  4'b1010, 32'h11223344, 32'h0));
    vecs.push_back(mk("ld0",           1, 0, 5'd0,  4'b0000, 32'h0,        32'h11003300));
    vecs.push_back(mk("st7 mask0",     1, 1, 5'd7,  4'b0000, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(mk("ld7",           1, 0, 5'd7,  4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("st1 unselected",0, 1, 5'd1,  4'b1111, 32'h87654321, 32'h0));
    vecs.push_back(mk("ld1",           1, 0, 5'd1,  4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("st25",          1, 1, 5'd25, 4'b1111, 32'hAAAAAAAA, 32'h0));
    vecs.push_back(mk("ld25",          1, 0, 5'd25, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("ld18",          1, 0, 5'd18, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("ld31",          1, 0, 5'd31, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("st17 ignored",  1, 1, 5'd17, 4'b1111, 32'h0,        32'h0));
    vecs.push_back(mk("ld17",          1, 0, 5'd17, 4'b0000, 32'h0,        Id));
    vecs.push_back(mk("ld8 IN0",       1, 0, 5'd8,  4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("ld16 CHG",      1, 0, 5'd16, 4'b0000, 32'h0,        32'h0));

    mmio_in     = '0;
    reset       = 1'b1;
    last_rd     = '0;
    load_issued = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, "idle");
    step();
    step();
    reset = 1'b0;
    for (int p = 0; p < 8; p++) check($sformatf("reset out%0d", p), mmio_out[p], 32'h0);

    req(1, 0, 5'd17, 4'b0, 32'h0, Id, "load ID");
    idle_step();

    foreach (vecs[i]) begin
      req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].wdata, vecs[i].exp,
          vecs[i].name);
    end
    idle_step();
    check("out3", mmio_out[3], 32'hDEAD1234);
    check("out0", mmio_out[0], 32'h11003300);
    check("out1 unselected", mmio_out[1], 32'h0);
    check("out7 mask0", mmio_out[7], 32'h0);

    // Outputs must not follow writeData before the edge.
    drive(1, 1, 5'd2, 4'b1111, 32'h55AA55AA, 32'h0, "st2");
    #1;
    check("out2 before edge", mmio_out[2], 32'h0);
    step();
    check("out2 after edge", mmio_out[2], 32'h55AA55AA);

    // Input synchroniser latency on port 5.
    mmio_in[5] = 32'hA5A5A5A5;
    req(1, 0, 5'd13, 4'b0, 32'h0, 32'h0,        "IN5 at t");
    req(1, 0, 5'd13, 4'b0, 32'h0, 32'h0,        "IN5 at t+1");
    req(1, 0, 5'd13, 4'b0, 32'h0, 32'hA5A5A5A5, "IN5 at t+2");
    req(1, 0, 5'd16, 4'b0, 32'h0, 32'h20,       "CHG after IN5");

    mmio_in[0] = 32'h1;
    idle_step();
    idle_step();
    req(1, 0, 5'd16, 4'b0,    32'h0,  32'h21, "CHG 0x21");
    req(1, 1, 5'd16, 4'b1110, 32'hFF, 32'h0,  "CHG upper bytes");
    req(1, 0, 5'd16, 4'b0,    32'h0,  32'h21, "CHG upper bytes ignored");
    req(1, 1, 5'd16, 4'b0001, 32'h01, 32'h0,  "CHG clear bit0");
    req(1, 0, 5'd16, 4'b0,    32'h0,  32'h20, "CHG after clear bit0");

    // Clear of bit 5 lands on the same edge as its set event.
    mmio_in[5] = 32'h5A5A5A5A;
    idle_step();
    req(1, 1, 5'd16, 4'b0001, 32'h20, 32'h0,  "CHG clear vs set");
    req(1, 0, 5'd16, 4'b0,    32'h0,  32'h20, "CHG set wins");
    req(1, 1, 5'd16, 4'b0001, 32'h20, 32'h0,  "CHG clear bit5");
    req(1, 0, 5'd16, 4'b0,    32'h0,  32'h0,  "CHG cleared");
    req(1, 0, 5'd13, 4'b0,    32'h0,  32'h5A5A5A5A, "IN5 second value");

    // Store, then reset with a load presented in the reset cycle.
    req(1, 1, 5'd0, 4'b1111, 32'hCAFEF00D, 32'h0, "st0 before reset");
    check("out0 before reset", mmio_out[0], 32'hCAFEF00D);
    reset = 1'b1;
    drive(1, 0, 5'd0, 4'b0, 32'h0, 32'h0, "load during reset");
    step();
    reset = 1'b0;
    check("out0 after reset", mmio_out[0], 32'h0);
    check("out2 after reset", mmio_out[2], 32'h0);

    // Load result pending when reset arrives.
    req(1, 0, 5'd17, 4'b0, 32'h0, Id, "load before reset");
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, "idle");
    step();
    reset = 1'b0;
    req(1, 0, 5'd13, 4'b0, 32'h0, 32'h0, "IN5 cleared by reset");
    req(1, 0, 5'd16, 4'b0, 32'h0, 32'h0, "CHG cleared by reset");
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
